// File: rtl/kumsaati_pkg.sv
// Shared types and constants for the MM:SS BCD countdown timer.
package kumsaati_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX_ONES     = 4'd9;
    localparam bcd_t BCD_MAX_TENS_SEC = 4'd5;

    // Saturate a preset digit to the largest legal value for its position.
    function automatic bcd_t bcd_clamp(input bcd_t val, input bcd_t max);
        return (val > max) ? max : val;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit; wraps 0 -> MAX and raises borrow_out to the next digit.
module bcd_digit_down
    import kumsaati_pkg::*;
#(
    parameter bcd_t MAX = BCD_MAX_ONES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec_en,
    input  logic       borrow_in,
    output logic [3:0] digit,
    output logic       borrow_out
);

    logic dec;

    assign dec        = dec_en & borrow_in;
    assign borrow_out = dec & (digit == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            digit <= 4'd0;
        end else if (load) begin
            digit <= bcd_clamp(load_val, MAX);
        end else if (dec) begin
            digit <= (digit == 4'd0) ? MAX : digit - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// MM:SS countdown timer with IDLE/RUN/PAUSE/DONE control and one-second prescaler.
// Optional feature: define COUNTDOWN_BLINK_EN to blink the display while in DONE.
module bcd_countdown_timer
    import kumsaati_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       load,
    input  logic [7:0] load_min,
    input  logic [7:0] load_sec,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done,
    output logic       blank
);

    localparam int unsigned PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    state_t               state, state_next;
    logic [PRESC_W-1:0]   presc, presc_next, presc_inc;
    logic                 tick, time_zero, time_one;
    logic                 load_en, dec_en, blank_next;
    logic                 b_so, b_st, b_mo, underflow;

    assign tick      = (presc == PRESC_W'(TICK_DIV - 1));
    assign presc_inc = tick ? '0 : presc + PRESC_W'(1);
    assign time_zero = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0000);
    assign time_one  = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0001);

    // Borrow chain, least significant digit first.
    bcd_digit_down #(.MAX(BCD_MAX_ONES)) u_sec_ones (
        .clk(clk), .rst(rst), .load(load_en), .load_val(load_sec[3:0]),
        .dec_en(dec_en), .borrow_in(1'b1), .digit(sec_ones), .borrow_out(b_so));
    bcd_digit_down #(.MAX(BCD_MAX_TENS_SEC)) u_sec_tens (
        .clk(clk), .rst(rst), .load(load_en), .load_val(load_sec[7:4]),
        .dec_en(dec_en), .borrow_in(b_so), .digit(sec_tens), .borrow_out(b_st));
    bcd_digit_down #(.MAX(BCD_MAX_ONES)) u_min_ones (
        .clk(clk), .rst(rst), .load(load_en), .load_val(load_min[3:0]),
        .dec_en(dec_en), .borrow_in(b_st), .digit(min_ones), .borrow_out(b_mo));
    bcd_digit_down #(.MAX(BCD_MAX_ONES)) u_min_tens (
        .clk(clk), .rst(rst), .load(load_en), .load_val(load_min[7:4]),
        .dec_en(dec_en), .borrow_in(b_mo), .digit(min_tens), .borrow_out(underflow));

    // Next-state, prescaler and digit-control decode.
    always_comb begin
        state_next = state;
        presc_next = presc;
        load_en    = 1'b0;
        dec_en     = 1'b0;
        blank_next = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    load_en    = 1'b1;
                    presc_next = '0;
                end else if (start) begin
                    presc_next = '0;
                    state_next = time_zero ? DONE : RUN;
                end
            end
            RUN: begin
                presc_next = presc_inc;
                dec_en     = tick;
                // Reaching 00:00 beats a coincident pause so PAUSE never holds zero time.
                if (tick && time_one) begin
                    state_next = DONE;
                    presc_next = '0;
                end else if (pause) begin
                    state_next = PAUSE;
                end
            end
            PAUSE: begin
                if (load) begin
                    load_en    = 1'b1;
                    presc_next = '0;
                    state_next = IDLE;
                end else if (start) begin
                    state_next = RUN;
                end
            end
            DONE: begin
                if (load) begin
                    load_en    = 1'b1;
                    presc_next = '0;
                    state_next = IDLE;
                end else begin
`ifdef COUNTDOWN_BLINK_EN
                    presc_next = presc_inc;
                    blank_next = blank ^ tick;
`else
                    presc_next = '0;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            presc   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
            blank   <= 1'b0;
        end else begin
            state   <= state_next;
            presc   <= presc_next;
            running <= (state_next == RUN);
            done    <= (state_next == DONE);
            blank   <= blank_next;
        end
    end

    // The top digit must never borrow: time cannot go below 00:00.
    assert property (@(posedge clk) disable iff (rst) !underflow);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed, table-driven bench for bcd_countdown_timer at TICK_DIV=4 (honours COUNTDOWN_BLINK_EN).
module tb_bcd_countdown_timer;

    logic       clk, rst, start, pause, load;
    logic [7:0] load_min, load_sec;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, done, blank;

    int total = 0;
    int bad   = 0;

    bcd_countdown_timer #(.TICK_DIV(4)) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .load(load),
        .load_min(load_min), .load_sec(load_sec),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .running(running), .done(done), .blank(blank));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        s, p, l;
        logic [7:0]  lm, ls;
        logic [15:0] t;
        logic        run, dn;
    } vec_t;

    vec_t vq[$];

    function automatic logic [15:0] cur_time();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic add(input logic s, p, l, input logic [7:0] lm, ls,
                       input logic [15:0] t, input logic run, dn);
        vec_t v;
        v.s = s; v.p = p; v.l = l; v.lm = lm; v.ls = ls; v.t = t; v.run = run; v.dn = dn;
        vq.push_back(v);
    endtask

    task automatic cyc(input logic s, p, l, input logic [7:0] lm, ls);
        start = s; pause = p; load = l; load_min = lm; load_sec = ls;
        @(posedge clk);
        #1;
        start = 1'b0; pause = 1'b0; load = 1'b0;
    endtask

    initial begin
        int n;
        logic exp_blank;
        rst = 1'b1; start = 1'b0; pause = 1'b0; load = 1'b0;
        load_min = 8'h00; load_sec = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_time", 32'(cur_time()), 32'h0000);
        chk("reset_running", 32'(running), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_blank", 32'(blank), 32'd0);

        // 00:03 countdown to DONE.
        add(0,0,1, 8'h00, 8'h03, 16'h0003, 0, 0);
        add(1,0,0, 8'h00, 8'h00, 16'h0003, 1, 0);
        for (int k = 0; k < 3; k++) add(0,0,0, 8'h00, 8'h00, 16'h0003, 1, 0);
        add(0,0,0, 8'h00, 8'h00, 16'h0002, 1, 0);
        for (int k = 0; k < 3; k++) add(0,0,0, 8'h00, 8'h00, 16'h0002, 1, 0);
        add(0,0,0, 8'h00, 8'h00, 16'h0001, 1, 0);
        for (int k = 0; k < 3; k++) add(0,0,0, 8'h00, 8'h00, 16'h0001, 1, 0);
        add(0,0,0, 8'h00, 8'h00, 16'h0000, 0, 1);
        add(1,0,0, 8'h00, 8'h00, 16'h0000, 0, 1);
        // 10:00 full borrow chain.
        add(0,0,1, 8'h10, 8'h00, 16'h1000, 0, 0);
        add(1,0,0, 8'h00, 8'h00, 16'h1000, 1, 0);
        for (int k = 0; k < 3; k++) add(0,0,0, 8'h00, 8'h00, 16'h1000, 1, 0);
        add(0,0,0, 8'h00, 8'h00, 16'h0959, 1, 0);
        add(0,1,0, 8'h00, 8'h00, 16'h0959, 0, 0);
        // Clamp, load ignored in RUN, start/pause priority, phase across pause.
        add(0,0,1, 8'hAB, 8'h7C, 16'h9959, 0, 0);
        add(1,0,0, 8'h00, 8'h00, 16'h9959, 1, 0);
        add(0,0,1, 8'h00, 8'h05, 16'h9959, 1, 0);
        add(1,1,0, 8'h00, 8'h00, 16'h9959, 0, 0);
        add(1,1,0, 8'h00, 8'h00, 16'h9959, 1, 0);
        add(0,0,0, 8'h00, 8'h00, 16'h9959, 1, 0);
        add(0,0,0, 8'h00, 8'h00, 16'h9958, 1, 0);
        add(0,1,0, 8'h00, 8'h00, 16'h9958, 0, 0);
        add(1,0,1, 8'h00, 8'h05, 16'h0005, 0, 0);
        add(1,0,0, 8'h00, 8'h00, 16'h0005, 1, 0);
        add(0,1,0, 8'h00, 8'h00, 16'h0005, 0, 0);
        // Start at 00:00 goes straight to DONE and holds.
        add(0,0,1, 8'h00, 8'h00, 16'h0000, 0, 0);
        add(1,0,0, 8'h00, 8'h00, 16'h0000, 0, 1);
        add(1,0,0, 8'h00, 8'h00, 16'h0000, 0, 1);
        add(0,0,0, 8'h00, 8'h00, 16'h0000, 0, 1);
        add(0,0,1, 8'h00, 8'h05, 16'h0005, 0, 0);
        add(0,1,0, 8'h00, 8'h00, 16'h0005, 0, 0);

        foreach (vq[i]) begin
            cyc(vq[i].s, vq[i].p, vq[i].l, vq[i].lm, vq[i].ls);
            chk($sformatf("vec%0d_time", i), 32'(cur_time()), 32'(vq[i].t));
            chk($sformatf("vec%0d_running", i), 32'(running), 32'(vq[i].run));
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(vq[i].dn));
            chk($sformatf("vec%0d_blank", i), 32'(blank), 32'd0);
        end

        // Pause mid-second, hold, resume: remaining two RUN cycles finish the second.
        cyc(0,0,1, 8'h01, 8'h30);
        cyc(1,0,0, 8'h00, 8'h00);
        chk("p_start_run", 32'(running), 32'd1);
        cyc(0,0,0, 8'h00, 8'h00);
        cyc(0,1,0, 8'h00, 8'h00);
        chk("p_paused", 32'(running), 32'd0);
        for (int k = 0; k < 10; k++) begin
            cyc(0,0,0, 8'h00, 8'h00);
            chk($sformatf("p_hold%0d_time", k), 32'(cur_time()), 32'h0130);
            chk($sformatf("p_hold%0d_running", k), 32'(running), 32'd0);
        end
        cyc(1,0,0, 8'h00, 8'h00);
        chk("p_resume_run", 32'(running), 32'd1);
        cyc(0,0,0, 8'h00, 8'h00);
        chk("p_resume1_time", 32'(cur_time()), 32'h0130);
        cyc(0,0,0, 8'h00, 8'h00);
        chk("p_resume2_time", 32'(cur_time()), 32'h0129);

        // Reset while running.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_run_time", 32'(cur_time()), 32'h0000);
        chk("rst_run_running", 32'(running), 32'd0);
        chk("rst_run_done", 32'(done), 32'd0);
        for (int k = 0; k < 5; k++) begin
            cyc(0,0,0, 8'h00, 8'h00);
            chk($sformatf("rst_idle%0d_time", k), 32'(cur_time()), 32'h0000);
            chk($sformatf("rst_idle%0d_running", k), 32'(running), 32'd0);
        end

        // Bounded wait for DONE from 00:02.
        cyc(0,0,1, 8'h00, 8'h02);
        cyc(1,0,0, 8'h00, 8'h00);
        n = 0;
        while (!done && n < 20) begin
            cyc(0,0,0, 8'h00, 8'h00);
            n++;
        end
        chk("wait_done_cycles", 32'(n), 32'd8);
        chk("wait_done_time", 32'(cur_time()), 32'h0000);

        // Blank behaviour while held in DONE, then cleared by load.
        for (int k = 1; k <= 12; k++) begin
            cyc(0,0,0, 8'h00, 8'h00);
`ifdef COUNTDOWN_BLINK_EN
            exp_blank = 1'((k / 4) % 2);
`else
            exp_blank = 1'b0;
`endif
            chk($sformatf("blank_done%0d", k), 32'(blank), 32'(exp_blank));
        end
        cyc(0,0,1, 8'h00, 8'h07);
        chk("blank_after_load", 32'(blank), 32'd0);
        chk("done_after_load", 32'(done), 32'd0);
        chk("time_after_load", 32'(cur_time()), 32'h0007);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
